pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Sequences the program counter and runs the instruction-memory fetch handshake for the core.
//  Holds the architectural PC and issues one fetch per instruction to imem.
//  Buffers each returned word in a single-entry output register for decode.
//  Applies branch redirects with PC-relative semantics (target = br_pc + br_offset + 1),
//  squashes wrong-path fetches, and stops once PC passes PC_LIMIT.
// PARAMETERS
//  AW        32   address/PC width (word addressing)
//  DW        32   instruction width
//  PC_LIMIT  255  last fetchable PC; fetching stops when pc > PC_LIMIT
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  run         in   1   fetch enable; level-sensitive
//  imem_req    out  1   fetch request; imem_addr is stable while imem_req=1 and imem_gnt=0
//  imem_addr   out  AW  fetch address
//  imem_gnt    in   1   imem accepts the request this cycle
//  imem_rvalid in   1   read data valid; arrives >=1 cycle after gnt, one response per grant
//  imem_rdata  in   DW  read data
//  inst_valid  out  1   output buffer holds a valid instruction
//  inst_data   out  DW  buffered instruction
//  inst_pc     out  AW  PC of the buffered instruction
//  inst_ready  in   1   consumer takes the instruction when inst_valid & inst_ready
//  br_valid    in   1   redirect request, single-cycle pulse
//  br_pc       in   AW  PC of the branching instruction
//  br_offset   in   AW  signed two's-complement offset
//  pc          out  AW  current architectural PC (next address to fetch)
//  done        out  1   pc > PC_LIMIT; no further fetches are issued
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; pc, imem_addr, inst_data, inst_pc = 0;
//    imem_req, inst_valid, done, drop = 0.
//  - FSM states: IDLE, REQ, WAIT, HOLD, DONE. All outputs are registered.
//  - IDLE: if run and pc<=PC_LIMIT -> REQ, latching imem_addr<=pc. If pc>PC_LIMIT -> DONE.
//    imem_rvalid is ignored, including stale responses that arrive after a reset.
//  - REQ: imem_req=1. On imem_gnt -> WAIT, and imem_req drops next cycle.
//  - WAIT: on imem_rvalid:
//    - drop=1: discard the data, clear drop, re-evaluate as in IDLE (run and pc).
//    - else: inst_data<=imem_rdata, inst_pc<=imem_addr, inst_valid<=1, pc<=pc+1, -> HOLD.
//  - HOLD: on inst_valid & inst_ready: inst_valid<=0, then re-evaluate as in IDLE.
//    Minimum issue-to-issue time is 4 cycles with a 1-cycle imem.
//  - Branch, computed by pc_next_unit:
//    - target = br_pc + br_offset + 1, modulo 2^AW; pc<=target in every state.
//    - REQ or WAIT: set drop=1. The in-flight request completes and its response is discarded.
//      imem_addr never changes while a request is pending.
//    - HOLD: inst_valid<=0 next edge. If inst_ready is high in the same cycle, the
//      transfer still counts (the consumer owns that squash).
//    - IDLE/DONE: done<=0 if target<=PC_LIMIT; the normal IDLE rules then apply.
//    - Back-to-back branches: last wins. A branch and a pc+1 update in the same cycle: the branch wins.
//  - Limit: done<=1 and -> DONE when re-evaluation finds pc>PC_LIMIT. The instruction
//    at PC_LIMIT itself is fetched.
//  - run low mid-operation: the outstanding REQ/WAIT/HOLD completes, then -> IDLE.
//    A request is never withdrawn once raised.
//  - imem_gnt/imem_rvalid outside REQ/WAIT: ignored.
// STRUCTURE
//  - cpu_pkg: fetch-state enum, PC_RESET (0), PC_LIMIT default, AW/DW defaults.
//  - Sub-module pc_next_unit (combinational): pc+1, branch target, limit compare.
//  - Top: FSM, drop flag, pc and output registers.
// TESTING
//  1. Reset, run=1, imem 1-cycle latency -> addrs 0,1,2,... in order; inst_pc matches; pc=3 after 3 transfers.
//  2. inst_ready held low 5 cycles in HOLD -> inst_valid/data stable, no new imem_req, pc unchanged.
//  3. br_valid in WAIT, br_pc=4, br_offset=-3 -> response dropped, next imem_addr=2, drop cleared.
//  4. Run to the limit -> addr 255 fetched, then done=1 and no req; branch br_pc=10,
//     offset=5 -> done=0, fetch at 16.
//  5. Branch with target 300 while DONE -> pc=300, done stays 1, no request.
//  6. reset=0 asserted in WAIT, rvalid arrives 1 cycle after release -> ignored,
//     all outputs 0, first fetch at addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-side types and defaults for the core.
// Fetch FSM state encoding, PC reset value and the default widths and PC limit.
package cpu_pkg;

  localparam int AW_DEF       = 32;
  localparam int DW_DEF       = 32;
  localparam int PC_LIMIT_DEF = 255;
  localparam int PC_RESET     = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } fetch_st_e;

endpackage

// File: rtl/pc_next_unit.sv
// Combinational next-PC arithmetic: pc+1, PC-relative branch target, limit checks.
// In: pc, br_pc, br_offset. Out: pc_inc, br_target, pc_over, tgt_over.
module pc_next_unit #(
  parameter int AW       = 32,
  parameter int PC_LIMIT = 255
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] br_offset,
  output logic [AW-1:0] pc_inc,
  output logic [AW-1:0] br_target,
  output logic          pc_over,
  output logic          tgt_over
);

  localparam logic [AW-1:0] LIM = AW'(PC_LIMIT);

  assign pc_inc    = pc + AW'(1);
  assign br_target = br_pc + br_offset + AW'(1);
  assign pc_over   = pc > LIM;
  assign tgt_over  = br_target > LIM;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer and imem fetch handshake with a one-entry decode buffer.
// Ports: clk/reset, run, imem req/gnt/rvalid bus, inst_* buffer, br_* redirect, pc, done.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc,
  input  logic          inst_ready,
  input  logic          br_valid,
  input  logic [AW-1:0] br_pc,
  input  logic [AW-1:0] br_offset,
  output logic [AW-1:0] pc,
  output logic          done
);

  fetch_st_e     st, st_n;
  logic          drop, drop_n;
  logic          req_n, vld_n, done_n;
  logic [AW-1:0] pc_n, addr_n, ipc_n;
  logic [DW-1:0] data_n;

  logic [AW-1:0] pc_inc, br_target;
  logic          pc_over, tgt_over;
  logic [AW-1:0] pc_eff;
  logic          eff_over, go_eval;

  pc_next_unit #(
    .AW      (AW),
    .PC_LIMIT(PC_LIMIT)
  ) u_next (
    .pc       (pc),
    .br_pc    (br_pc),
    .br_offset(br_offset),
    .pc_inc   (pc_inc),
    .br_target(br_target),
    .pc_over  (pc_over),
    .tgt_over (tgt_over)
  );

  // A same-cycle redirect is the PC the next fetch decision must use.
  assign pc_eff   = br_valid ? br_target : pc;
  assign eff_over = br_valid ? tgt_over : pc_over;

  always_comb begin
    st_n    = st;
    pc_n    = pc;
    req_n   = imem_req;
    addr_n  = imem_addr;
    vld_n   = inst_valid;
    data_n  = inst_data;
    ipc_n   = inst_pc;
    done_n  = done;
    drop_n  = drop;
    go_eval = 1'b0;
    if (br_valid) pc_n = br_target;
    unique case (st)
      ST_IDLE: go_eval = 1'b1;
      ST_REQ: begin
        if (br_valid) drop_n = 1'b1;
        if (imem_gnt) begin
          req_n = 1'b0;
          st_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          // A redirect landing with the data makes it wrong-path too.
          if (drop || br_valid) begin
            drop_n  = 1'b0;
            go_eval = 1'b1;
          end else begin
            data_n = imem_rdata;
            ipc_n  = imem_addr;
            vld_n  = 1'b1;
            pc_n   = pc_inc;
            st_n   = ST_HOLD;
          end
        end else if (br_valid) begin
          drop_n = 1'b1;
        end
      end
      ST_HOLD: begin
        if (br_valid || (inst_valid && inst_ready)) begin
          vld_n = 1'b0;
          st_n  = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (br_valid && !tgt_over) begin
          done_n = 1'b0;
          st_n   = ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
    if (go_eval) begin
      if (eff_over) begin
        st_n   = ST_DONE;
        done_n = 1'b1;
      end else if (run) begin
        st_n   = ST_REQ;
        req_n  = 1'b1;
        addr_n = pc_eff;
        done_n = 1'b0;
      end else begin
        st_n   = ST_IDLE;
        done_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      pc         <= AW'(PC_RESET);
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
      done       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      st         <= st_n;
      pc         <= pc_n;
      imem_req   <= req_n;
      imem_addr  <= addr_n;
      inst_valid <= vld_n;
      inst_data  <= data_n;
      inst_pc    <= ipc_n;
      done       <= done_n;
      drop       <= drop_n;
    end
  end

endmodule
